// File: rtl/display_scan_scheduler.sv
// -----------------------------------------------------------------------------
// display_scan_scheduler
//
// Scans a multi-digit 7-segment display. It owns the digit slot timing and a
// double-buffered value path: the producer writes into a pending buffer, and the
// pending value is copied into the displayed register only at a frame boundary.
// This keeps a frame from showing half of an old value and half of a new one.
//
// Optional build macro: LZ_SUPPRESS_EN. When defined, leading zero digits are
// kept dark (digit 0 always stays lit). When undefined, all enabled digits show.
//
// Parameters:
//   CLK_DIV   clock cycles per digit slot (>= 2)
//   N_DIGITS  number of scanned digits (2..8)
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   value_in     hex value, nibble k drives digit k (digit 0 is rightmost)
//   value_valid  producer offers value_in
//   value_ready  pending buffer is empty, so a value can be accepted
//   digit_en     per-digit enable mask, 0 forces that digit dark
//   hexa         nibble of the digit being scanned (to the segment encoder)
//   blank        1 when no digit is lit in the current slot
//   anodes       one-hot active-low digit enables
//   frame_done   one-cycle pulse after the last digit slot ends
//   fsm_state    current scan state (0 = BLANK, 1 = SCAN), for observation
// -----------------------------------------------------------------------------
module display_scan_scheduler #(
  parameter int CLK_DIV  = 100000,
  parameter int N_DIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [3:0]              hexa,
  output logic                    blank,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_done,
  output logic                    fsm_state
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  state_t                state;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pending_full;
  logic [4*N_DIGITS-1:0] display_reg;
  logic [N_DIGITS-1:0]   lz_reg;

  logic                  tick;
  logic                  last;
  logic                  commit;
  logic [IW-1:0]         idx_nx;
  state_t                state_nx;
  logic [4*N_DIGITS-1:0] disp_nx;
  logic [N_DIGITS-1:0]   lz_calc;
  logic [N_DIGITS-1:0]   lz_nx;
  logic [3:0]            hexa_nx;
  logic [N_DIGITS-1:0]   anodes_nx;
  logic                  lit_nx;

  // Handshake: a transfer happens on a rising clock edge where value_valid and
  // value_ready are both 1. value_ready depends only on the pending register,
  // never on value_valid. The producer keeps value_valid and value_in stable
  // until that edge, and value_in is sampled only on that edge.
  assign value_ready = !pending_full;
  assign fsm_state   = state;

  assign tick   = (prescaler == PW'(CLK_DIV - 1));
  assign last   = (idx == IW'(N_DIGITS - 1));
  // A commit can only happen on the tick that closes the last slot, so a
  // newly displayed value always starts on digit 0.
  assign commit = tick && last && pending_full;

  assign idx_nx   = last ? '0 : idx + 1'b1;
  assign disp_nx  = commit ? pending : display_reg;
  assign state_nx = (commit || state == SCAN) ? SCAN : BLANK;
  assign lz_nx    = commit ? lz_calc : lz_reg;

  // Leading-zero mask of the pending value: bit k is 1 when digit k may light.
  always_comb begin
    lz_calc = '1;
`ifdef LZ_SUPPRESS_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
        if (pending[4*k +: 4] != 4'h0) seen = 1'b1;
        lz_calc[k] = seen || (k == 0);
      end
    end
`endif
  end

  // Output values for the slot that starts on the next tick. They are built
  // from the post-tick index, state and display value so the registered outputs
  // line up with the slot they describe.
  always_comb begin
    hexa_nx   = 4'h0;
    anodes_nx = '1;
    lit_nx    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_nx == IW'(k) && state_nx == SCAN) begin
        hexa_nx = disp_nx[4*k +: 4];
        lit_nx  = digit_en[k] && lz_nx[k];
        if (lit_nx) anodes_nx[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler    <= '0;
      idx          <= '0;
      state        <= BLANK;
      pending      <= '0;
      pending_full <= 1'b0;
      display_reg  <= '0;
      lz_reg       <= '1;
      hexa         <= 4'h0;
      anodes       <= '1;
      blank        <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= tick && last;

      // Capture needs an empty buffer and commit needs a full one, so the two
      // never coincide; a producer blocked at frame end lands a cycle later.
      if (value_valid && !pending_full) begin
        pending      <= value_in;
        pending_full <= 1'b1;
      end else if (commit) begin
        pending_full <= 1'b0;
      end

      // digit_en is sampled only here, so a mask change never cuts a slot.
      if (tick) begin
        idx         <= idx_nx;
        state       <= state_nx;
        display_reg <= disp_nx;
        lz_reg      <= lz_nx;
        hexa        <= hexa_nx;
        anodes      <= anodes_nx;
        blank       <= !lit_nx;
      end
    end
  end

endmodule
